pid_incremental: RTL and testbench
==================================

// Module: pid_incremental
// PURPOSE
//  Discrete incremental PID stage fed by the signed error (ref - yk) from the
//  error subtractor; produces the servo control word uk once per sample tick.
//  Law: uk[k] = sat( uk[k-1] + (K0*e[k] + K1*e[k-1] + K2*e[k-2]) >>> Q ).
//  One shared signed multiplier, time-multiplexed over three cycles. Output
//  feeds the PWM/actuator stage downstream.
// PARAMETERS
//  N   19  width of error, coefficients and uk (signed two's complement)
//  Q   10  fractional bits of K0/K1/K2 (1.0 = 2**Q)
// PORTS
//  clk     in   1  system clock, all state on rising edge
//  reset   in   1  synchronous, active-high; clears all state
//  start   in   1  sample strobe; honoured only in IDLE
//  error   in   N  signed e[k]; sampled on the edge that accepts start
//  K0      in   N  signed coefficient for e[k]   (Q fractional bits)
//  K1      in   N  signed coefficient for e[k-1]
//  K2      in   N  signed coefficient for e[k-2]
//  uk      out  N  signed control output, registered, held between updates
//  done    out  1  one-cycle pulse: uk updated this cycle
//  busy    out  1  high in every state except IDLE
//  sat     out  1  registered with uk: last update was clipped
// BEHAVIOUR
//  - Reset: state=IDLE; uk=0, done=0, busy=0, sat=0; e1=e2=0; acc=0.
//    Reset mid-computation aborts it; no done pulse; history is zeroed.
//  - States: IDLE -> M0 -> M1 -> M2 -> UPD -> IDLE.
//    IDLE: on edge with start=1 latch error->e0, K0..K2, acc<=0, go M0.
//    M0: acc += K0*e0.  M1: acc += K1*e1.  M2: acc += K2*e2.
//    UPD: uk <= sat(uk + (acc >>> Q)); e2<=e1; e1<=e0; done<=1; go IDLE.
//  - Latency: start accepted at edge E0 -> uk/done valid after edge E4;
//    next start can be accepted at edge E5 (1 sample per 5 clocks max).
//  - start while busy: ignored, not queued. start held high: re-accepted
//    in IDLE after each completion.
//  - Inputs error/K* may change while busy; only latched copies are used.
//  - Arithmetic: products full 2N bits; acc 2N+2 bits (no overflow of 3
//    terms); >>>Q is arithmetic shift = floor (toward -inf), no rounding;
//    sum with sign-extended uk in 2N+3 bits, then clip to
//    [-2**(N-1), 2**(N-1)-1]; sat=1 iff clipping occurred.
//  - uk, sat change only in UPD (or reset); done low in all other cycles.
//  - busy=1 in M0,M1,M2,UPD; done and busy are never high in the same
//    cycle after UPD completes (done registered on UPD exit, busy low).
// TESTING (N=19, Q=10)
//  1 K0=1024,K1=K2=0; start with error=100 twice -> uk=100 then 200; done
//    pulses exactly 4 cycles after each accepting edge; sat=0.
//  2 K0=0,K1=1024,K2=0; errors 5,7,9 -> uk 0,5,12 (history shift check);
//    K2=1024 alone with 5,7,9 -> uk 0,0,5.
//  3 K0=512, error=-3 -> uk=-2 (floor of -1.5); error=3 -> uk=-1.
//  4 K0=1024, error=262143 repeatedly -> uk=262143, sat=1 from 2nd sample;
//    error=-262144 thereafter -> uk reaches -262144, sat=1 on clip.
//  5 start pulsed during M1 -> ignored, single done, uk as for one sample;
//    start held high 20 cycles -> exactly 4 done pulses, 5 cycles apart.
//  6 reset asserted in M2 -> next cycle uk=0,busy=0,done=0; following
//    sample with K1=1024 gives uk=0 (e1 was cleared).

Source files
------------

// File: rtl/pid_incremental.sv
// Incremental PID stage: uk[k] = sat(uk[k-1] + (K0*e[k] + K1*e[k-1] + K2*e[k-2]) >>> Q).
// A single signed multiplier is shared across three cycles (M0..M2), and
// the control word is updated in UPD. One sample is taken per 5 clocks at most.
module pid_incremental #(
    parameter int N = 19,
    parameter int Q = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] error,
    input  logic [N-1:0] K0,
    input  logic [N-1:0] K1,
    input  logic [N-1:0] K2,
    output logic [N-1:0] uk,
    output logic         done,
    output logic         busy,
    output logic         sat
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] M0   = 3'd1;
    localparam logic [2:0] M1   = 3'd2;
    localparam logic [2:0] M2   = 3'd3;
    localparam logic [2:0] UPD  = 3'd4;

    // Widths: full product, three-term accumulator, and the final uk + delta sum.
    localparam int PW = 2 * N;
    localparam int AW = 2 * N + 2;
    localparam int SW = 2 * N + 3;

    localparam logic signed [SW-1:0] SUM_MAX = SW'((64'sd1 <<< (N - 1)) - 64'sd1);
    localparam logic signed [SW-1:0] SUM_MIN = ~SUM_MAX;

    logic [2:0]           state;
    logic signed [N-1:0]  e0, e1, e2;
    logic signed [N-1:0]  k0, k1, k2;
    logic signed [AW-1:0] acc;
    logic signed [N-1:0]  uk_r;

    logic signed [N-1:0]  mul_a, mul_b;
    logic signed [PW-1:0] prod;
    logic signed [SW-1:0] sum;

    // Clip the wide sum into the N-bit output range; MSB of the result flags clipping.
    function automatic logic [N:0] clip(input logic signed [SW-1:0] v);
        logic [N:0] r;
        if (v > SUM_MAX) begin
            r = {1'b1, SUM_MAX[N-1:0]};
        end else if (v < SUM_MIN) begin
            r = {1'b1, SUM_MIN[N-1:0]};
        end else begin
            r = {1'b0, v[N-1:0]};
        end
        return r;
    endfunction

    // Route the coefficient/history pair for the current multiply cycle.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            M0: begin
                mul_a = k0;
                mul_b = e0;
            end
            M1: begin
                mul_a = k1;
                mul_b = e1;
            end
            M2: begin
                mul_a = k2;
                mul_b = e2;
            end
            default: begin
                mul_a = '0;
                mul_b = '0;
            end
        endcase
    end

    assign prod = PW'(mul_a) * PW'(mul_b);

    // Floor shift of the accumulated increment, added to the sign-extended previous output.
    assign sum  = SW'(uk_r) + SW'(acc >>> Q);

    assign uk   = uk_r;
    assign busy = (state != IDLE);

    // Sequencer, latched operands, accumulator, history and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            uk_r  <= '0;
            done  <= 1'b0;
            sat   <= 1'b0;
            e0    <= '0;
            e1    <= '0;
            e2    <= '0;
            k0    <= '0;
            k1    <= '0;
            k2    <= '0;
            acc   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        e0    <= $signed(error);
                        k0    <= $signed(K0);
                        k1    <= $signed(K1);
                        k2    <= $signed(K2);
                        acc   <= '0;
                        state <= M0;
                    end
                end
                M0: begin
                    acc   <= acc + AW'(prod);
                    state <= M1;
                end
                M1: begin
                    acc   <= acc + AW'(prod);
                    state <= M2;
                end
                M2: begin
                    acc   <= acc + AW'(prod);
                    state <= UPD;
                end
                UPD: begin
                    {sat, uk_r} <= clip(sum);
                    e2          <= e1;
                    e1          <= e0;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pid_incremental.sv
// Self-checking bench for pid_incremental: a sample-level reference model
// plus directed vectors with hand-computed expectations.
module tb_pid_incremental;

    localparam int N = 19;
    localparam int Q = 10;
    localparam longint UMAX = (64'sd1 <<< (N - 1)) - 1;
    localparam longint UMIN = -(64'sd1 <<< (N - 1));

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] error, K0, K1, K2, uk;
    logic         done, busy, sat;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    pid_incremental #(.N(N), .Q(Q)) dut (
        .clk(clk), .reset(reset), .start(start), .error(error),
        .K0(K0), .K1(K1), .K2(K2), .uk(uk), .done(done), .busy(busy), .sat(sat)
    );

    // Reference model: sample-level PID law with a cycle countdown for latency.
    longint m_uk = 0, m_e1 = 0, m_e2 = 0;
    longint le, lk0, lk1, lk2;
    bit     m_sat = 0, m_done = 0;
    int     m_cnt = 0;

    always @(posedge clk) begin
        longint s, v;
        if (reset) begin
            m_uk = 0; m_e1 = 0; m_e2 = 0; m_sat = 0; m_done = 0; m_cnt = 0;
        end else begin
            m_done = 0;
            if (m_cnt == 0) begin
                if (start) begin
                    le  = longint'($signed(error));
                    lk0 = longint'($signed(K0));
                    lk1 = longint'($signed(K1));
                    lk2 = longint'($signed(K2));
                    m_cnt = 4;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) begin
                    s = lk0 * le + lk1 * m_e1 + lk2 * m_e2;
                    v = m_uk + (s >>> Q);
                    m_sat = (v > UMAX) || (v < UMIN);
                    m_uk  = (v > UMAX) ? UMAX : ((v < UMIN) ? UMIN : v);
                    m_e2  = m_e1;
                    m_e1  = le;
                    m_done = 1;
                end
            end
        end
    end

    function automatic void chk(string name, longint act, longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_uk", longint'($signed(uk)), m_uk);
            chk("model_done", longint'(done), longint'(m_done));
            chk("model_busy", longint'(busy), longint'(m_cnt != 0));
            chk("model_sat", longint'(sat), longint'(m_sat));
        end
    end

    task automatic do_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic set_k(input int a, input int b, input int c);
        K0 = N'(a); K1 = N'(b); K2 = N'(c);
    endtask

    // One sample; returns edges from accept to done (-1 on timeout).
    task automatic sample(input int e, output int lat);
        @(negedge clk); error = N'(e); start = 1'b1;
        @(negedge clk); start = 1'b0; error = 19'h2AAAA;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (done) begin lat = k; break; end
        end
        if (lat < 0) chk("done_timeout", 0, 1);
    endtask

    initial begin : main
        int lat, ndone, first, prev, gapbad;
        reset = 1'b1; start = 1'b0; error = '0; K0 = '0; K1 = '0; K2 = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_uk", longint'($signed(uk)), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_sat", longint'(sat), 0);
        reset = 1'b0;

        // 1: unity proportional gain
        set_k(1024, 0, 0);
        sample(100, lat); chk("t1_lat", lat, 4); chk("t1_uk", longint'($signed(uk)), 100);
        sample(100, lat); chk("t1_lat2", lat, 4); chk("t1_uk2", longint'($signed(uk)), 200);
        chk("t1_sat", longint'(sat), 0);

        // 2: history shift through K1 then K2
        do_reset(); set_k(0, 1024, 0);
        sample(5, lat); chk("t2a_uk0", longint'($signed(uk)), 0);
        sample(7, lat); chk("t2a_uk1", longint'($signed(uk)), 5);
        sample(9, lat); chk("t2a_uk2", longint'($signed(uk)), 12);
        do_reset(); set_k(0, 0, 1024);
        sample(5, lat); chk("t2b_uk0", longint'($signed(uk)), 0);
        sample(7, lat); chk("t2b_uk1", longint'($signed(uk)), 0);
        sample(9, lat); chk("t2b_uk2", longint'($signed(uk)), 5);

        // 3: floor behaviour of the arithmetic shift
        do_reset(); set_k(512, 0, 0);
        sample(-3, lat); chk("t3_uk0", longint'($signed(uk)), -2);
        sample(3, lat);  chk("t3_uk1", longint'($signed(uk)), -1);

        // 4: saturation at both rails
        do_reset(); set_k(1024, 0, 0);
        sample(262143, lat); chk("t4_uk0", longint'($signed(uk)), 262143); chk("t4_sat0", longint'(sat), 0);
        sample(262143, lat); chk("t4_uk1", longint'($signed(uk)), 262143); chk("t4_sat1", longint'(sat), 1);
        sample(-262144, lat); chk("t4_uk2", longint'($signed(uk)), -1); chk("t4_sat2", longint'(sat), 0);
        sample(-262144, lat); chk("t4_uk3", longint'($signed(uk)), -262144); chk("t4_sat3", longint'(sat), 1);

        // 5a: start pulse while busy is ignored
        do_reset(); set_k(1024, 0, 0);
        @(negedge clk); error = N'(40); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin @(negedge clk); if (done) ndone++; end
        chk("t5_single_done", ndone, 1);
        chk("t5_uk", longint'($signed(uk)), 40);

        // 5b: start held high for 20 cycles
        @(negedge clk); start = 1'b1;
        ndone = 0; first = -1; prev = -1; gapbad = 0;
        for (int k = 1; k <= 28; k++) begin
            @(negedge clk);
            if (k == 20) start = 1'b0;
            if (done) begin
                ndone++;
                if (prev >= 0 && (k - prev) != 5) gapbad++;
                if (first < 0) first = k;
                prev = k;
            end
        end
        chk("t5_held_count", ndone, 4);
        chk("t5_held_gap", gapbad, 0);
        chk("t5_held_first", first, 5);

        // 6: reset mid-computation clears state and history
        do_reset(); set_k(1024, 1024, 0);
        sample(50, lat); chk("t6_uk_pre", longint'($signed(uk)), 50);
        @(negedge clk); error = N'(30); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        chk("t6_rst_uk", longint'($signed(uk)), 0);
        chk("t6_rst_busy", longint'(busy), 0);
        chk("t6_rst_done", longint'(done), 0);
        reset = 1'b0;
        set_k(0, 1024, 0);
        sample(77, lat); chk("t6_uk_post", longint'($signed(uk)), 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
